// File: rtl/usb_ebi_master.sv
// usb_ebi_master: programmable-timing initiator for the 8-bit USB external-bus interface.
// Define USB_EBI_ADDR_CACHE_EN to skip the ALE phase when the address repeats.
module usb_ebi_master #(
  parameter int ALE_CYCLES    = 1,
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1,
  parameter int CNT_W         = 4
) (
  input  logic       clk,
  input  logic       reset_i,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic [7:0] usb_addr,
  output logic       usb_ale_n,
  output logic       usb_ce_n,
  output logic       usb_rd_n,
  output logic       usb_wr_n,
  output logic [7:0] usb_d_out,
  output logic       usb_d_oe,
  input  logic [7:0] usb_d_in
);
  typedef enum logic [2:0] {IDLE, ALE, SETUP, STROBE, HOLD} state_t;
  localparam logic [CNT_W-1:0] ALE_L    = CNT_W'(ALE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETUP_L  = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] STROBE_L = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_L   = CNT_W'(HOLD_CYCLES - 1);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic wr_q, wr_nx, acc, last, skip;
  assign cmd_ready = state == IDLE && !reset_i;
  assign busy = state != IDLE;
  assign acc = cmd_valid && cmd_ready;
  assign last = cnt == '0;
  assign wr_nx = acc ? cmd_write : wr_q;
`ifdef USB_EBI_ADDR_CACHE_EN
  // usb_addr always holds the last accepted address, so only a valid flag is needed
  logic cache_vld;
  always_ff @(posedge clk or posedge reset_i)
    if (reset_i) cache_vld <= 1'b0;
    else if (acc) cache_vld <= 1'b1;
  assign skip = cache_vld && usb_addr == cmd_addr;
`else
  assign skip = 1'b0;
`endif
  always_comb begin
    state_n = state;
    cnt_n = last ? cnt : cnt - 1'b1;
    case (state)
      IDLE:   if (acc) begin state_n = skip ? SETUP : ALE; cnt_n = skip ? SETUP_L : ALE_L; end
      ALE:    if (last) begin state_n = SETUP; cnt_n = SETUP_L; end
      SETUP:  if (last) begin state_n = STROBE; cnt_n = STROBE_L; end
      STROBE: if (last) begin state_n = HOLD; cnt_n = HOLD_L; end
      HOLD:   if (last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // bus pins are registered from the next state so they change with the phase edge
  always_ff @(posedge clk or posedge reset_i)
    if (reset_i) begin
      state     <= IDLE;
      cnt       <= '0;
      wr_q      <= 1'b0;
      usb_addr  <= '0;
      usb_d_out <= '0;
      usb_ale_n <= 1'b1;
      usb_ce_n  <= 1'b1;
      usb_rd_n  <= 1'b1;
      usb_wr_n  <= 1'b1;
      usb_d_oe  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      wr_q      <= wr_nx;
      usb_addr  <= acc ? cmd_addr : usb_addr;
      usb_d_out <= acc && cmd_write ? cmd_wdata : usb_d_out;
      usb_ale_n <= state_n != ALE;
      usb_ce_n  <= state_n == IDLE;
      usb_rd_n  <= !(state_n == STROBE && !wr_nx);
      usb_wr_n  <= !(state_n == STROBE && wr_nx);
      usb_d_oe  <= wr_nx && state_n != IDLE && state_n != ALE;
      rsp_valid <= state == HOLD && last;
      rsp_rdata <= state == STROBE && last && !wr_q ? usb_d_in : rsp_rdata;
    end
endmodule
